// File: rtl/mem_request_unit.sv
// Memory request unit: owns the PC, drives instruction fetch, and fronts the data cache
// port with a posted store buffer, load ordering behind stores, and drain-then-halt.
module mem_request_unit #(
  parameter int                WORD_W     = 32,
  parameter logic [WORD_W-1:0] PC_INIT    = '0,
  parameter int                WBUF_DEPTH = 2
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              pc_we,
  input  logic [WORD_W-1:0] pc_next,
  output logic [WORD_W-1:0] pc,
  input  logic              ifetch_en,
  output logic [WORD_W-1:0] instr,
  output logic              instr_valid,
  input  logic              dREN_req,
  input  logic              dWEN_req,
  input  logic [WORD_W-1:0] daddr_req,
  input  logic [WORD_W-1:0] dstore_req,
  output logic              dreq_ready,
  output logic [WORD_W-1:0] dload_data,
  input  logic              halt_in,
  output logic              imemREN,
  output logic [WORD_W-1:0] imemaddr,
  input  logic              ihit,
  input  logic [WORD_W-1:0] imemload,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  output logic              halt
);

  localparam int PTR_W = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(WBUF_DEPTH + 1);

  typedef enum logic {IDLE = 1'b0, LOAD = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              halted_q, halted_d;
  logic              halt_q, halt_d;

  logic [WORD_W-1:0] addr_mem [WBUF_DEPTH];
  logic [WORD_W-1:0] data_mem [WBUF_DEPTH];

  logic buf_empty, buf_full, store_acc, drain, deq, load_start, load_done;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(WBUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    buf_empty  = (count_q == '0);
    buf_full   = (count_q == CNT_W'(WBUF_DEPTH));
    // A full buffer never passes a store through, even if it dequeues this cycle.
    store_acc  = dWEN_req & ~halted_q & ~buf_full;
    drain      = ~buf_empty & (state_q == IDLE);
    deq        = drain & dhit;
    load_start = (state_q == IDLE) & dREN_req & ~halted_q & buf_empty;
    load_done  = (state_q == LOAD) & dhit;
  end

  always_comb begin
    pc_d     = pc_we ? pc_next : pc_q;
    head_d   = deq ? ptr_inc(head_q) : head_q;
    tail_d   = store_acc ? ptr_inc(tail_q) : tail_q;
    count_d  = count_q;
    if (store_acc && !deq)
      count_d = count_q + 1'b1;
    else if (deq && !store_acc)
      count_d = count_q - 1'b1;
    state_d  = state_q;
    case (state_q)
      IDLE:    if (load_start) state_d = LOAD;
      LOAD:    if (load_done)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    halted_d = halted_q | halt_in;
    halt_d   = halted_q & buf_empty & (state_q == IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q  <= IDLE;
      pc_q     <= PC_INIT;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      halted_q <= 1'b0;
      halt_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      halted_q <= halted_d;
      halt_q   <= halt_d;
      if (store_acc) begin
        addr_mem[tail_q] <= daddr_req;
        data_mem[tail_q] <= dstore_req;
      end
    end
  end

  assign pc          = pc_q;
  assign imemaddr    = pc_q;
  assign imemREN     = ifetch_en & ~halted_q;
  assign instr       = imemload;
  assign instr_valid = imemREN & ihit;
  assign dmemREN     = (state_q == LOAD);
  assign dmemWEN     = drain;
  assign dmemaddr    = (state_q == LOAD) ? daddr_req : (drain ? addr_mem[head_q] : '0);
  assign dmemstore   = drain ? data_mem[head_q] : '0;
  assign dreq_ready  = store_acc | load_done;
  assign dload_data  = load_done ? dmemload : '0;
  assign halt        = halt_q;

endmodule

// File: tb/tb_mem_request_unit.sv
// Bench for mem_request_unit: directed scenarios then random traffic, checked every cycle
// against a queue-based reference model that also plays the role of the cache memory.
module tb_mem_request_unit;
  localparam int          W     = 32;
  localparam int          DEPTH = 2;
  localparam logic [31:0] PCI   = 32'h200;

  logic          CLK = 1'b0, nRST;
  logic          pc_we, ifetch_en, dREN_req, dWEN_req, halt_in, ihit, dhit;
  logic [W-1:0]  pc_next, daddr_req, dstore_req, imemload, dmemload;
  logic [W-1:0]  pc, instr, dload_data, imemaddr, dmemaddr, dmemstore;
  logic          instr_valid, dreq_ready, imemREN, dmemREN, dmemWEN, halt;

  mem_request_unit #(.WORD_W(W), .PC_INIT(PCI), .WBUF_DEPTH(DEPTH)) dut (
    .CLK(CLK), .nRST(nRST), .pc_we(pc_we), .pc_next(pc_next), .pc(pc),
    .ifetch_en(ifetch_en), .instr(instr), .instr_valid(instr_valid),
    .dREN_req(dREN_req), .dWEN_req(dWEN_req), .daddr_req(daddr_req),
    .dstore_req(dstore_req), .dreq_ready(dreq_ready), .dload_data(dload_data),
    .halt_in(halt_in), .imemREN(imemREN), .imemaddr(imemaddr), .ihit(ihit),
    .imemload(imemload), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
    .dmemstore(dmemstore), .dhit(dhit), .dmemload(dmemload), .halt(halt)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {logic [31:0] a; logic [31:0] d;} st_t;
  st_t         mq[$];
  bit          m_loading, m_halted, m_halt, chk_en;
  logic [31:0] m_pc;
  logic [31:0] mem [8];
  int          errors = 0, checks = 0;
  bit          e_ready;
  logic [31:0] obs_load, obs_waddr;
  logic        obs_ready, obs_ren, obs_imem, obs_halt, obs_wen;
  int          rd_cycles, wr_cycles;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: inputs already set at the negedge; compare, then advance the model.
  task automatic cycle();
    bit e_acc, e_drain, e_done, e_imem, start, new_halt;
    if (m_loading) dmemload = mem[daddr_req[4:2]];
    else           dmemload = $urandom;
    #1;
    e_imem  = ifetch_en && !m_halted;
    e_acc   = dWEN_req && !m_halted && (mq.size() < DEPTH);
    e_drain = (mq.size() > 0) && !m_loading;
    e_done  = m_loading && dhit;
    e_ready = e_acc || e_done;
    if (chk_en) begin
      check("pc", pc, m_pc);
      check("imemaddr", imemaddr, m_pc);
      check("imemREN", 32'(imemREN), 32'(e_imem));
      check("instr", instr, imemload);
      check("instr_valid", 32'(instr_valid), 32'(e_imem && ihit));
      check("dmemREN", 32'(dmemREN), 32'(m_loading));
      check("dmemWEN", 32'(dmemWEN), 32'(e_drain));
      check("ren_wen_excl", 32'(dmemREN & dmemWEN), 32'd0);
      if (m_loading) check("dmemaddr_ld", dmemaddr, daddr_req);
      else if (e_drain) begin
        check("dmemaddr_st", dmemaddr, mq[0].a);
        check("dmemstore", dmemstore, mq[0].d);
      end
      check("dreq_ready", 32'(dreq_ready), 32'(e_ready));
      if (e_done) check("dload_data", dload_data, mem[daddr_req[4:2]]);
      check("halt", 32'(halt), 32'(m_halt));
    end
    obs_ready = dreq_ready; obs_load = dload_data; obs_waddr = dmemaddr;
    obs_ren = dmemREN; obs_wen = dmemWEN; obs_imem = imemREN; obs_halt = halt;
    if (dmemREN) rd_cycles++;
    if (dmemWEN) wr_cycles++;
    @(posedge CLK);
    if (!nRST) begin
      mq.delete(); m_loading = 0; m_halted = 0; m_halt = 0; m_pc = PCI;
    end else begin
      start    = !m_loading && dREN_req && !m_halted && (mq.size() == 0);
      new_halt = m_halted && (mq.size() == 0) && !m_loading;
      if (pc_we) m_pc = pc_next;
      if (e_drain && dhit) begin
        mem[mq[0].a[4:2]] = mq[0].d;
        void'(mq.pop_front());
      end
      if (e_acc) mq.push_back('{a: daddr_req, d: dstore_req});
      if (e_done) m_loading = 0;
      else if (start) m_loading = 1;
      m_halt = new_halt;
      if (halt_in) m_halted = 1;
    end
    chk_en = 1;
    @(negedge CLK);
  endtask

  task automatic set_req(input bit wen, input bit ren, input logic [31:0] a, input logic [31:0] d);
    dWEN_req = wen; dREN_req = ren; daddr_req = a; dstore_req = d;
  endtask

  initial begin
    bit got;
    nRST = 0; pc_we = 0; pc_next = 0; ifetch_en = 0; halt_in = 0; ihit = 0; dhit = 0;
    imemload = 0; dmemload = 0;
    set_req(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) mem[i] = $urandom;
    @(negedge CLK);
    cycle(); cycle();

    // Reset values
    nRST = 1;
    check("rst_pc", pc, PCI);
    check("rst_imemaddr", imemaddr, PCI);
    check("rst_halt", 32'(halt), 32'd0);
    check("rst_dmemREN", 32'(dmemREN), 32'd0);
    check("rst_dmemWEN", 32'(dmemWEN), 32'd0);
    check("rst_dmemaddr", dmemaddr, 32'd0);
    check("rst_dmemstore", dmemstore, 32'd0);
    check("rst_dload_data", dload_data, 32'd0);
    cycle();
    pc_we = 1; pc_next = 32'h204; cycle();
    pc_we = 0; check("pc_we", pc, 32'h204);

    // Three back-to-back stores into a 2-entry buffer
    dhit = 0;
    set_req(1, 0, 32'h10, 32'hA); cycle(); check("st1_ready", 32'(obs_ready), 32'd1);
    set_req(1, 0, 32'h14, 32'hB); cycle(); check("st2_ready", 32'(obs_ready), 32'd1);
    set_req(1, 0, 32'h18, 32'hC); cycle(); check("st3_stall", 32'(obs_ready), 32'd0);
    dhit = 1; cycle();
    check("st3_no_pass", 32'(obs_ready), 32'd0);
    check("drain_0x10", obs_waddr, 32'h10);
    dhit = 0; cycle(); check("st3_accept", 32'(obs_ready), 32'd1);
    set_req(0, 0, 0, 0); dhit = 1;
    cycle(); check("drain_0x14", obs_waddr, 32'h14);
    cycle(); check("drain_0x18", obs_waddr, 32'h18);
    dhit = 0; cycle();

    // Store then load of the same address: load waits, then sees the stored value
    set_req(1, 0, 32'h20, 32'h55); cycle();
    set_req(0, 1, 32'h20, 0); cycle(); cycle();
    check("ld_waits_store", 32'(obs_ren), 32'd0);
    dhit = 1; got = 0;
    for (int i = 0; i < 10 && !got; i++) begin cycle(); got = obs_ready; end
    check("ld_completes", 32'(got), 32'd1);
    check("ld_value", obs_load, 32'h55);
    set_req(0, 0, 0, 0); dhit = 0; cycle();
    check("ld_ready_once", 32'(obs_ready), 32'd0);

    // Load with three cache wait cycles
    rd_cycles = 0; wr_cycles = 0;
    set_req(0, 1, 32'h24, 0);
    cycle(); cycle(); cycle(); cycle();
    dhit = 1; cycle();
    check("ld_wait_ready", 32'(obs_ready), 32'd1);
    check("ld_ren_cycles", 32'(rd_cycles), 32'd4);
    check("ld_no_wen", 32'(wr_cycles), 32'd0);
    set_req(0, 0, 0, 0); dhit = 0; cycle();

    // Halt with two buffered stores
    ifetch_en = 1;
    set_req(1, 0, 32'h08, 32'h77); cycle();
    set_req(1, 0, 32'h0C, 32'h88); halt_in = 1; cycle();
    check("halt_same_cycle_store", 32'(obs_ready), 32'd1);
    halt_in = 0; set_req(0, 0, 0, 0); dhit = 1; cycle();
    check("halt_imemREN_off", 32'(obs_imem), 32'd0);
    dhit = 0; set_req(1, 0, 32'h1C, 32'h99); cycle();
    check("halted_store_ignored", 32'(obs_ready), 32'd0);
    set_req(0, 0, 0, 0); dhit = 1; cycle();
    check("halt_low_draining", 32'(obs_halt), 32'd0);
    dhit = 0; cycle();
    check("halt_low_after_drain", 32'(obs_halt), 32'd0);
    cycle(); check("halt_rises", 32'(obs_halt), 32'd1);
    cycle(); check("halt_held", 32'(obs_halt), 32'd1);

    // Reset with a full buffer and a pending load
    nRST = 0; ifetch_en = 0; cycle();
    nRST = 1; cycle();
    set_req(1, 0, 32'h04, 32'h11); cycle();
    set_req(1, 0, 32'h08, 32'h22); cycle();
    set_req(0, 1, 32'h24, 0); cycle();
    nRST = 0; pc_we = 1; pc_next = 32'h300; cycle();
    nRST = 1; pc_we = 0; set_req(0, 0, 0, 0);
    check("rst2_dmemREN", 32'(dmemREN), 32'd0);
    check("rst2_dmemWEN", 32'(dmemWEN), 32'd0);
    check("rst2_imemREN", 32'(imemREN), 32'd0);
    check("rst2_pc", pc, PCI);
    cycle(); check("rst2_buffer_empty", 32'(obs_wen), 32'd0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      int r;
      nRST      = ($urandom_range(0, 99) != 0);
      ifetch_en = 1'($urandom_range(0, 1));
      ihit      = 1'($urandom_range(0, 1));
      imemload  = $urandom;
      pc_we     = 1'($urandom_range(0, 1));
      pc_next   = $urandom;
      dhit      = 1'($urandom_range(0, 1));
      if (!(dREN_req && !e_ready)) begin
        r = int'($urandom_range(0, 3));
        if (r == 0)      set_req(0, 1, {27'd0, 3'($urandom_range(0, 7)), 2'd0}, 0);
        else if (r == 1) set_req(1, 0, {27'd0, 3'($urandom_range(0, 7)), 2'd0}, $urandom);
        else             set_req(0, 0, 0, 0);
      end
      if (!nRST) set_req(0, 0, 0, 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
